// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The master side is the requesting core; the slave side is the responder.
interface data_mem_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        busy;

  modport master (
    output enable,
    output wr,
    output addr,
    output data_in,
    input  data_out,
    input  done,
    input  busy
  );

  modport slave (
    input  enable,
    input  wr,
    input  addr,
    input  data_in,
    output data_out,
    output done,
    output busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the core's load/store stage.
// A request is accepted only while idle, waits a fixed number of cycles,
// then completes with a one-cycle done pulse. Requests seen while busy are dropped.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int         WORDS      = 1 << DEPTH_LOG2;
  localparam logic [3:0] LOAD_VALUE = 4'(LATENCY - 1);

  typedef enum logic {
    IDLE,
    WAIT
  } stateT;

  stateT                  state;
  stateT                  nextState;
  logic [3:0]             count;
  logic                   latchedWr;
  logic [DEPTH_LOG2-1:0]  latchedIndex;
  logic [15:0]            latchedData;
  logic [15:0]            dataOutReg;
  logic                   doneReg;
  logic                   accept;
  logic                   complete;
  logic [15:0]            mem [WORDS];

  // Byte-address bit 0 and bits above the array size are deliberately ignored (aliasing).
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.addr[0], bus.addr[15:DEPTH_LOG2+1]};

  // State register; reset discards any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode: accept from IDLE on enable, complete from WAIT once the counter runs out.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          accept    = 1'b1;
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          complete  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, latency countdown, and registered done/read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= 4'd0;
      latchedWr    <= 1'b0;
      latchedIndex <= '0;
      latchedData  <= 16'h0000;
      dataOutReg   <= 16'h0000;
      doneReg      <= 1'b0;
    end else begin
      doneReg <= complete;
      if (accept) begin
        count        <= LOAD_VALUE;
        latchedWr    <= bus.wr;
        latchedIndex <= bus.addr[DEPTH_LOG2:1];
        latchedData  <= bus.data_in;
      end else if (state == WAIT && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (complete && !latchedWr) begin
        dataOutReg <= mem[latchedIndex];
      end
    end
  end

  // Array write commits only at the completion edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (complete && latchedWr) begin
      mem[latchedIndex] <= latchedData;
    end
  end

  assign bus.busy     = (state == WAIT);
  assign bus.done     = doneReg;
  assign bus.data_out = dataOutReg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic checked against a word-indexed reference memory.
module tb_data_mem_responder;

  localparam int LAT  = 4;
  localparam int B2BN = 12;

  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;

  logic [15:0] refMem [int];

  data_mem_responder_if busFour ();
  data_mem_responder_if busOne ();

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dutFour (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busFour.slave)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dutOne (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busOne.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wordIdx(input logic [15:0] a);
    return (int'(a) >> 1) % 1024;
  endfunction

  // Issue one request on the LATENCY=4 responder and report what was observed.
  task automatic runRequest(input logic isWrite, input logic [15:0] a, input logic [15:0] d,
                            output int cycles, output int busyCycles, output logic doneSeen,
                            output logic busyAtDone, output logic doneAfter, output logic [15:0] readData);
    @(negedge clk);
    busFour.enable  = 1'b1;
    busFour.wr      = isWrite;
    busFour.addr    = a;
    busFour.data_in = d;
    @(negedge clk);
    busFour.enable  = 1'b0;
    busFour.wr      = 1'($urandom);
    busFour.addr    = 16'($urandom);
    busFour.data_in = 16'($urandom);
    busyCycles = busFour.busy ? 1 : 0;
    cycles     = 0;
    doneSeen   = 1'b0;
    busyAtDone = 1'b1;
    readData   = busFour.data_out;
    while (!doneSeen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (busFour.done) begin
        doneSeen   = 1'b1;
        busyAtDone = busFour.busy;
        readData   = busFour.data_out;
      end else if (busFour.busy) begin
        busyCycles++;
      end
    end
    @(negedge clk);
    doneAfter = busFour.done;
    if (isWrite && doneSeen) refMem[wordIdx(a)] = d;
  endtask

  task automatic test_write_read();
    int cyc, bc;
    logic ds, bd, da;
    logic [15:0] rd;
    runRequest(1'b1, 16'h0010, 16'hBEEF, cyc, bc, ds, bd, da, rd);
    checkCount++; if (ds !== 1'b1) $display("[TB] FAIL wr_done_seen: got %0b want 1", ds); else passCount++;
    checkCount++; if (cyc != LAT) $display("[TB] FAIL wr_latency: got %0d want %0d", cyc, LAT); else passCount++;
    checkCount++; if (bc != LAT) $display("[TB] FAIL wr_busy_cycles: got %0d want %0d", bc, LAT); else passCount++;
    checkCount++; if (bd !== 1'b0) $display("[TB] FAIL wr_busy_at_done: got %0b want 0", bd); else passCount++;
    checkCount++; if (da !== 1'b0) $display("[TB] FAIL wr_done_one_cycle: got %0b want 0", da); else passCount++;
    runRequest(1'b0, 16'h0010, 16'h0000, cyc, bc, ds, bd, da, rd);
    checkCount++; if (cyc != LAT) $display("[TB] FAIL rd_latency: got %0d want %0d", cyc, LAT); else passCount++;
    checkCount++; if (bc != LAT) $display("[TB] FAIL rd_busy_cycles: got %0d want %0d", bc, LAT); else passCount++;
    checkCount++; if (rd !== 16'hBEEF) $display("[TB] FAIL rd_data: got %h want beef", rd); else passCount++;
    checkCount++; if (da !== 1'b0) $display("[TB] FAIL rd_done_one_cycle: got %0b want 0", da); else passCount++;
  endtask

  task automatic test_reset();
    int doneCount = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkCount++; if (busFour.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busFour.busy); else passCount++;
    checkCount++; if (busFour.done !== 1'b0) $display("[TB] FAIL reset_done: got %0b want 0", busFour.done); else passCount++;
    checkCount++; if (busFour.data_out !== 16'h0000) $display("[TB] FAIL reset_data_out: got %h want 0000", busFour.data_out); else passCount++;
    busFour.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      busFour.addr = 16'($urandom);
      busFour.wr   = 1'($urandom);
      @(negedge clk);
      if (busFour.done) doneCount++;
    end
    checkCount++; if (doneCount != 0) $display("[TB] FAIL idle_no_done: got %0d pulses want 0", doneCount); else passCount++;
  endtask

  task automatic test_alias();
    int cyc, bc;
    logic ds, bd, da;
    logic [15:0] rd;
    runRequest(1'b1, 16'h0011, 16'h1234, cyc, bc, ds, bd, da, rd);
    runRequest(1'b0, 16'h0810, 16'h0000, cyc, bc, ds, bd, da, rd);
    checkCount++; if (ds !== 1'b1) $display("[TB] FAIL alias_done: got %0b want 1", ds); else passCount++;
    checkCount++; if (rd !== 16'h1234) $display("[TB] FAIL alias_data: got %h want 1234", rd); else passCount++;
  endtask

  task automatic test_churn();
    int cyc, bc;
    logic ds, bd, da;
    logic [15:0] rd;
    int doneCount = 0;
    logic [15:0] seen = 16'h0000;
    runRequest(1'b1, 16'h0020, 16'h00AA, cyc, bc, ds, bd, da, rd);
    @(negedge clk);
    busFour.enable  = 1'b1;
    busFour.wr      = 1'b0;
    busFour.addr    = 16'h0020;
    @(negedge clk);
    busFour.wr      = 1'b1;
    busFour.data_in = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busFour.done) begin
        doneCount++;
        seen = busFour.data_out;
        busFour.enable = 1'b0;
      end
    end
    busFour.enable = 1'b0;
    checkCount++; if (doneCount != 1) $display("[TB] FAIL churn_done_count: got %0d want 1", doneCount); else passCount++;
    checkCount++; if (seen !== 16'h00AA) $display("[TB] FAIL churn_read_data: got %h want 00aa", seen); else passCount++;
    runRequest(1'b0, 16'h0020, 16'h0000, cyc, bc, ds, bd, da, rd);
    checkCount++; if (rd !== refMem[wordIdx(16'h0020)]) $display("[TB] FAIL churn_no_write: got %h want %h", rd, refMem[wordIdx(16'h0020)]); else passCount++;
  endtask

  task automatic test_reset_mid_write();
    int cyc, bc;
    logic ds, bd, da;
    logic [15:0] rd;
    int doneCount = 0;
    runRequest(1'b1, 16'h0030, 16'h1111, cyc, bc, ds, bd, da, rd);
    @(negedge clk);
    busFour.enable  = 1'b1;
    busFour.wr      = 1'b1;
    busFour.addr    = 16'h0030;
    busFour.data_in = 16'h5555;
    @(negedge clk);
    busFour.enable = 1'b0;
    checkCount++; if (busFour.busy !== 1'b1) $display("[TB] FAIL midrst_accepted: got %0b want 1", busFour.busy); else passCount++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkCount++; if (busFour.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %0b want 0", busFour.busy); else passCount++;
    checkCount++; if (busFour.done !== 1'b0) $display("[TB] FAIL midrst_done: got %0b want 0", busFour.done); else passCount++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busFour.done) doneCount++;
    end
    checkCount++; if (doneCount != 0) $display("[TB] FAIL midrst_no_done: got %0d want 0", doneCount); else passCount++;
    runRequest(1'b0, 16'h0030, 16'h0000, cyc, bc, ds, bd, da, rd);
    checkCount++; if (rd !== 16'h1111) $display("[TB] FAIL midrst_old_value: got %h want 1111", rd); else passCount++;
  endtask

  task automatic test_random();
    int cyc, bc;
    logic ds, bd, da;
    logic [15:0] rd;
    int slots [6];
    logic [15:0] a;
    logic isWrite;
    int s;
    for (int i = 0; i < 6; i++) begin
      slots[i] = int'($urandom_range(64, 1023));
      a = 16'((slots[i] << 1) | (int'($urandom_range(0, 31)) << 11) | int'($urandom_range(0, 1)));
      runRequest(1'b1, a, 16'($urandom), cyc, bc, ds, bd, da, rd);
    end
    for (int i = 0; i < 20; i++) begin
      s = int'($urandom_range(0, 5));
      a = 16'((slots[s] << 1) | (int'($urandom_range(0, 31)) << 11) | int'($urandom_range(0, 1)));
      isWrite = 1'($urandom);
      runRequest(isWrite, a, 16'($urandom), cyc, bc, ds, bd, da, rd);
      checkCount++; if (cyc != LAT) $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, LAT); else passCount++;
      if (!isWrite) begin
        checkCount++;
        if (rd !== refMem[wordIdx(a)]) $display("[TB] FAIL rand_read[%0d] addr %h: got %h want %h", i, a, rd, refMem[wordIdx(a)]);
        else passCount++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        pendWr [$];
    logic [15:0] pendData [$];
    logic [15:0] lastWrite = 16'h0000;
    logic        w;
    logic [15:0] d;
    int presented = 0;
    int completed = 0;
    int lastDone  = 0;
    busOne.addr = 16'h0040;
    @(negedge clk);
    for (int n = 0; n < 200 && completed < B2BN; n++) begin
      if (busOne.done) begin
        checkCount++; if (n - lastDone != 2) $display("[TB] FAIL b2b_spacing[%0d]: got %0d want 2", completed, n - lastDone); else passCount++;
        lastDone = n;
        if (pendWr.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL b2b_extra_done: got 1 unexpected pulse want 0");
        end else begin
          w = pendWr.pop_front();
          d = pendData.pop_front();
          if (w) begin
            lastWrite = d;
          end else begin
            checkCount++;
            if (busOne.data_out !== lastWrite) $display("[TB] FAIL b2b_read[%0d]: got %h want %h", completed, busOne.data_out, lastWrite);
            else passCount++;
          end
        end
        completed++;
      end
      if (!busOne.busy && presented < B2BN) begin
        w = (presented % 2 == 0);
        d = 16'($urandom);
        busOne.enable  = 1'b1;
        busOne.wr      = w;
        busOne.data_in = d;
        pendWr.push_back(w);
        pendData.push_back(d);
        presented++;
      end else if (presented >= B2BN) begin
        busOne.enable = 1'b0;
      end
      @(negedge clk);
    end
    busOne.enable = 1'b0;
    checkCount++; if (completed != B2BN) $display("[TB] FAIL b2b_completed: got %0d want %0d", completed, B2BN); else passCount++;
  endtask

  // Top-level sequence: power-on reset, then each scenario in turn.
  initial begin
    rst_n           = 1'b0;
    busFour.enable  = 1'b0;
    busFour.wr      = 1'b0;
    busFour.addr    = 16'h0000;
    busFour.data_in = 16'h0000;
    busOne.enable   = 1'b0;
    busOne.wr       = 1'b0;
    busOne.addr     = 16'h0000;
    busOne.data_in  = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_write_read();
    test_reset();
    test_alias();
    test_churn();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that services the load/store requests issued by the core's memory stage. It sits at the far end of the memory-enable / read-write control pair (LW: enable=1, wr=0; SW: enable=1, wr=1), holds a word-organised data array, and completes each request after a fixed latency. It reports completion with a one-cycle `done` pulse and asserts `busy` so the pipeline stalls while a request is outstanding.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, log2 of the number of 16-bit words in the array (1024 words).
- `LATENCY`, 4, cycles from request acceptance to completion; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: request strobe; sampled only when not busy.
- `wr` input 1: 1 = write (store), 0 = read (load); sampled with `enable`.
- `addr` input 16: byte address; word index = `addr[DEPTH_LOG2:1]`.
- `data_in` input 16: store data; sampled with `enable`.
- `data_out` output 16: read data; valid in the `done` cycle of a read, held afterwards.
- `done` output 1: one-cycle completion pulse for reads and writes.
- `busy` output 1: request outstanding; new requests ignored.

## Operation
- States: IDLE, WAIT. Reset state IDLE.
- IDLE: at a rising edge with `enable`=1, accept: latch `wr`, word index, `data_in`; load counter with `LATENCY`-1; go to WAIT. `enable`=0 stays in IDLE.
- WAIT: each edge with counter≠0 decrements the counter. At the edge where counter=0: complete the request, go to IDLE.
- Completion edge, read: `data_out` <= array[latched index]; `done` <= 1.
- Completion edge, write: array[latched index] <= latched data; `done` <= 1; `data_out` unchanged.
- `done` is registered and clears at the next edge.
- `busy` = (state == WAIT); combinational from state.
- Inputs that change while busy have no effect on the outstanding request. `enable` while busy is dropped, not queued; the requester must hold `enable` until it sees `busy`=0.
- Address rules: `addr[0]` is ignored, because accesses are word-aligned. Address bits above `DEPTH_LOG2` are ignored, so addresses alias modulo 2^(DEPTH_LOG2+1) bytes. There is no error response.
- Read-after-write: the write commits at its completion edge. Any read accepted afterwards returns the new value.
- Reset: asynchronous assertion forces state IDLE, `busy`=0, `done`=0, `data_out`=16'h0000, counter=0. An outstanding request is discarded and a pending write never commits. Array contents are not reset; they are undefined until written.
- Counter width is 4 bits. `LATENCY`=1 loads 0, so the request completes at the first edge after acceptance.

## Timing
- Request sampled at edge E0 → `busy` high from E0 until E_LATENCY. `done` is high for the single cycle between E_LATENCY and E_LATENCY+1. `data_out` updates at E_LATENCY for reads.
- `busy` falls at the same edge `done` rises. The earliest next acceptance is E_LATENCY+1.
- Throughput: one request per LATENCY+1 cycles with `enable` held high continuously.
- No combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-simulation, then release → `busy`=0, `done`=0, `data_out`=0x0000. With `enable`=0 held for 20 cycles → no `done` pulse.
- Write then read, LATENCY=4: SW addr=0x0010 data=0xBEEF, then LW addr=0x0010 → write `done` 4 cycles after acceptance. Read `done` 4 cycles after its acceptance with `data_out`=0xBEEF. `busy` is high exactly 4 cycles per request.
- Aliasing/alignment: write 0x1234 to addr=0x0011, then read addr=0x0810 (DEPTH_LOG2=10) → `data_out`=0x1234.
- Input churn while busy: accept LW addr=0x0020 (holding 0x00AA). During WAIT, drive `enable`=1, `wr`=1, addr=0x0020, data=0xFFFF → `data_out`=0x00AA, only one `done`. A later read of 0x0020 returns 0x00AA, so the dropped write never happened.
- Reset mid-write: accept SW addr=0x0030 data=0x5555 over old value 0x1111. Pulse `rst_n` low two cycles after acceptance → no `done`, `busy`=0. A later read returns 0x1111.
- LATENCY=1 back-to-back: hold `enable`=1 with alternating SW/LW to addr=0x0040 → `done` every 2nd cycle and read data equals the prior write.
